// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - RV32I fetch program counter with prioritised redirects and a circular return-address stack
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           trap_en,
  input  logic [XLEN-1:0]                trap_vec,
  input  logic                           jmp_en,
  input  logic                           branch_en,
  input  logic [XLEN-1:0]                jmp,
  input  logic                           call_en,
  input  logic                           ret_en,
  output logic [XLEN-1:0]                pc,
  output logic [XLEN-1:0]                pc_next,
  output logic                           redirected,
  output logic                           misalign,
  output logic [XLEN-1:0]                misalign_addr,
  output logic                           ras_underflow,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int              PW         = $clog2(RAS_DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [CW-1:0]   CNT_FULL   = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   ras_waddr;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_ok;
  logic            push;
  logic            pop;
  logic            replace;
  logic            underflow_d;
  logic            jmp_req;
  logic            jmp_bad;
  logic [XLEN-1:0] pc_d;
  logic            redirect_d;
  logic            misalign_d;

  assign pc_next   = pc + STEP_V;
  assign ras_empty = (ras_count == '0);
  // ras_ptr is the next free slot, so the newest entry sits one below it
  assign top_idx   = ras_ptr - PW'(1);
  assign ras_top   = ras_mem[top_idx];
  assign jmp_req   = jmp_en | branch_en;
  assign jmp_bad   = (jmp & ALIGN_MASK) != '0;

  assign ras_ok      = ~trap_en & ~stall;
  assign replace     = ras_ok & call_en & ret_en & ~ras_empty;
  assign push        = ras_ok & call_en & ~replace;
  assign pop         = ras_ok & ret_en & ~call_en & ~ras_empty;
  assign underflow_d = ras_ok & ret_en & ras_empty;
  assign ras_waddr   = replace ? top_idx : ras_ptr;

  always_comb begin
    pc_d       = pc;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    if (trap_en) begin
      pc_d       = trap_vec;
      redirect_d = 1'b1;
    end else if (jmp_req) begin
      if (jmp_bad) begin
        misalign_d = 1'b1;
      end else begin
        pc_d       = jmp;
        redirect_d = 1'b1;
      end
    end else if (ret_en && !stall) begin
      if (!ras_empty) begin
        pc_d       = ras_top;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_next;
      end
    end else if (!stall) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      redirected    <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      ras_underflow <= 1'b0;
      ras_count     <= '0;
      ras_ptr       <= '0;
    end else begin
      pc            <= pc_d;
      redirected    <= redirect_d;
      misalign      <= misalign_d;
      ras_underflow <= underflow_d;
      if (misalign_d) begin
        misalign_addr <= jmp;
      end
      if (push) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (ras_count != CNT_FULL) begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (pop) begin
        ras_ptr   <= ras_ptr - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // Stack contents carry no reset; ras_count alone defines validity
  always_ff @(posedge clk) begin
    if (push || replace) begin
      ras_mem[ras_waddr] <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based reference model
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        trap_en;
  logic [31:0] trap_vec;
  logic        jmp_en;
  logic        branch_en;
  logic [31:0] jmp;
  logic        call_en;
  logic        ret_en;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirected;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        ras_underflow;
  logic [2:0]  ras_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_mis_addr;
  bit          m_red;
  bit          m_mis;
  bit          m_uf;
  logic [31:0] m_ras[$];

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0100), .STEP(4), .ALIGN_BITS(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .trap_en(trap_en), .trap_vec(trap_vec),
    .jmp_en(jmp_en), .branch_en(branch_en), .jmp(jmp), .call_en(call_en), .ret_en(ret_en),
    .pc(pc), .pc_next(pc_next), .redirected(redirected), .misalign(misalign),
    .misalign_addr(misalign_addr), .ras_underflow(ras_underflow), .ras_count(ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},            pc,            m_pc);
    check({tag, ".pc_next"},       pc_next,       m_pc + 32'd4);
    check({tag, ".redirected"},    {31'd0, redirected},    {31'd0, m_red});
    check({tag, ".misalign"},      {31'd0, misalign},      {31'd0, m_mis});
    check({tag, ".misalign_addr"}, misalign_addr, m_mis_addr);
    check({tag, ".ras_underflow"}, {31'd0, ras_underflow}, {31'd0, m_uf});
    check({tag, ".ras_count"},     {29'd0, ras_count},     m_ras.size());
  endtask

  task automatic model_reset();
    m_pc       = 32'h0000_0100;
    m_mis_addr = '0;
    m_red      = 0;
    m_mis      = 0;
    m_uf       = 0;
    m_ras.delete();
  endtask

  task automatic idle();
    stall = 0; trap_en = 0; trap_vec = '0; jmp_en = 0; branch_en = 0;
    jmp = '0; call_en = 0; ret_en = 0;
  endtask

  // One clock: predict from the rules, advance the DUT, compare everything.
  task automatic step(input string tag);
    logic [31:0] ret_addr;
    logic [31:0] top;
    bit          nonempty;
    bit          ras_ok;
    ret_addr = m_pc + 32'd4;
    nonempty = m_ras.size() > 0;
    top      = nonempty ? m_ras[m_ras.size()-1] : 32'd0;
    ras_ok   = !trap_en && !stall;
    m_red = 0; m_mis = 0; m_uf = 0;
    if (trap_en) begin
      m_pc = trap_vec; m_red = 1;
    end else if (jmp_en || branch_en) begin
      if (jmp % 4 != 0) begin
        m_mis = 1; m_mis_addr = jmp;
      end else begin
        m_pc = jmp; m_red = 1;
      end
    end else if (ret_en && !stall) begin
      if (nonempty) begin
        m_pc = top; m_red = 1;
      end else begin
        m_pc = ret_addr;
      end
    end else if (!stall) begin
      m_pc = ret_addr;
    end
    if (ras_ok) begin
      if (ret_en && !nonempty) m_uf = 1;
      if (call_en && ret_en && nonempty) begin
        void'(m_ras.pop_back());
        m_ras.push_back(ret_addr);
      end else if (call_en) begin
        m_ras.push_back(ret_addr);
        if (m_ras.size() > 4) m_ras.delete(0);
      end else if (ret_en && nonempty) begin
        void'(m_ras.pop_back());
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) step("seq");

    jmp_en = 1; jmp = 32'h10; step("goto10");
    idle(); stall = 1; step("stall1"); step("stall2");
    jmp_en = 1; jmp = 32'h80; step("stall_jmp");
    idle(); step("after_jmp");

    jmp_en = 1; jmp = 32'h20; step("goto20");
    jmp = 32'h82; step("misalign");
    idle(); step("after_mis");

    jmp_en = 1; jmp = 32'h40; step("goto40");
    call_en = 1; jmp = 32'h200; step("call0");
    for (int i = 1; i <= 5; i++) begin
      jmp = 32'h200 + i * 32'h100;
      step($sformatf("call%0d", i));
    end
    idle(); ret_en = 1;
    for (int i = 1; i <= 5; i++) step($sformatf("ret%0d", i));

    idle(); call_en = 1; jmp_en = 1; jmp = 32'h500; step("call_pre_trap");
    trap_en = 1; trap_vec = 32'h1C0; jmp_en = 1; jmp = 32'h82;
    ret_en = 1; call_en = 1; stall = 1; step("trap");

    idle(); call_en = 1; ret_en = 1; step("call_ret_swap");
    idle(); ret_en = 1; step("ret_after_swap");
    idle(); call_en = 1; ret_en = 1; step("call_ret_empty");

    idle(); jmp_en = 1; jmp = 32'hFFFF_FFFC; step("goto_top");
    idle(); step("wrap");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #2;
    reset = 1'b0;
    step("post_reset");

    for (int i = 0; i < 400; i++) begin
      idle();
      trap_en   = ($urandom_range(0, 99) < 4);
      trap_vec  = $urandom & 32'hFFFF_FFFC;
      stall     = ($urandom_range(0, 3) == 0);
      jmp_en    = ($urandom_range(0, 9) == 0);
      branch_en = ($urandom_range(0, 9) == 0);
      jmp       = $urandom;
      if ($urandom_range(0, 4) != 0) jmp[1:0] = 2'b00;
      call_en   = ($urandom_range(0, 4) == 0);
      ret_en    = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
